// File: rtl/led_mode_sequencer.sv
// Button-driven LED pattern sequencer: debounced buttons step a prescaled position counter through four display modes.
// Optional status LEDs are enabled by defining LED_SEQ_STATUS_EN.
module led_mode_sequencer #(
    parameter int LOG2DELAY     = 22,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_N,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    output logic [4:0] LEDS,
    output logic [1:0] MODE,
    output logic       LEDR_N,
    output logic       LEDG_N
);

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_SCAN = 2'd2,
        MODE_BAR  = 2'd3
    } mode_t;

    localparam int EV_RESTART = 0;
    localparam int EV_NEXT    = 1;
    localparam int EV_PAUSE   = 2;
    localparam int EV_DIR     = 3;

    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE    = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
    localparam logic [LOG2DELAY-1:0]     PRESC_ONE = {{(LOG2DELAY-1){1'b0}}, 1'b1};

    logic [3:0] btn_raw;
    logic [3:0] btn_events;
`ifdef LED_SEQ_STATUS_EN
    logic [3:0] btn_stable;
`endif

    assign btn_raw = {BTN3, BTN2, BTN1, ~BTN_N};

    // Per button: entry flop, two synchroniser flops, debouncer, rising-edge event pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic                     in_reg;
            logic                     sync1_reg;
            logic                     sync2_reg;
            logic                     stable_reg;
            logic                     stable_prev_reg;
            logic                     event_reg;
            logic [DEBOUNCE_BITS-1:0] count_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    in_reg          <= 1'b0;
                    sync1_reg       <= 1'b0;
                    sync2_reg       <= 1'b0;
                    stable_reg      <= 1'b0;
                    stable_prev_reg <= 1'b0;
                    event_reg       <= 1'b0;
                    count_reg       <= '0;
                end else begin
                    in_reg          <= btn_raw[gi];
                    sync1_reg       <= in_reg;
                    sync2_reg       <= sync1_reg;
                    stable_prev_reg <= stable_reg;
                    event_reg       <= stable_reg & ~stable_prev_reg;
                    if (sync2_reg == stable_reg) begin
                        count_reg <= '0;
                    end else if (count_reg == '1) begin
                        stable_reg <= sync2_reg;
                        count_reg  <= '0;
                    end else begin
                        count_reg <= count_reg + DB_ONE;
                    end
                end
            end

            assign btn_events[gi] = event_reg;
`ifdef LED_SEQ_STATUS_EN
            assign btn_stable[gi] = stable_reg;
`endif
        end
    endgenerate

    mode_t                mode_reg, mode_next;
    logic                 run_reg, run_next;
    logic                 dir_reg, dir_next;       // 0 = up, 1 = down
    logic [4:0]           pos_reg, pos_next;
    logic [LOG2DELAY-1:0] presc_reg, presc_next;
    logic [4:0]           leds_reg, leds_next;
    logic [4:0]           pos_max;
    logic                 tick;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_reg  <= MODE_GRAY;
            run_reg   <= 1'b1;
            dir_reg   <= 1'b0;
            pos_reg   <= '0;
            presc_reg <= '0;
            leds_reg  <= '0;
        end else begin
            mode_reg  <= mode_next;
            run_reg   <= run_next;
            dir_reg   <= dir_next;
            pos_reg   <= pos_next;
            presc_reg <= presc_next;
            leds_reg  <= leds_next;
        end
    end

    always_comb begin
        mode_next  = mode_reg;
        run_next   = run_reg;
        dir_next   = dir_reg;
        pos_next   = pos_reg;
        presc_next = run_reg ? presc_reg + PRESC_ONE : presc_reg;
        tick       = run_reg && (presc_reg == '1);

        case (mode_reg)
            MODE_SCAN: pos_max = 5'd4;
            MODE_BAR:  pos_max = 5'd5;
            default:   pos_max = 5'd31;
        endcase

        if (tick) begin
            if (!dir_reg) begin
                pos_next = (pos_reg == pos_max) ? 5'd0 : pos_reg + 5'd1;
            end else begin
                pos_next = (pos_reg == 5'd0) ? pos_max : pos_reg - 5'd1;
            end
        end

        // Event actions override the tick; restart is applied last so it wins outright.
        if (btn_events[EV_NEXT]) begin
            mode_next  = mode_t'(mode_reg + 2'd1);
            pos_next   = '0;
            presc_next = '0;
        end
        if (btn_events[EV_PAUSE]) begin
            run_next = ~run_reg;
        end
        if (btn_events[EV_DIR]) begin
            dir_next = ~dir_reg;
        end
        if (btn_events[EV_RESTART]) begin
            mode_next  = MODE_GRAY;
            run_next   = 1'b1;
            dir_next   = 1'b0;
            pos_next   = '0;
            presc_next = '0;
        end

        // Decoded from the next state so the display changes on the same edge as pos/mode.
        // For BAR at pos 5 the shift overflows to 0 and the subtraction wraps to 5'b11111.
        case (mode_next)
            MODE_BIN:  leds_next = pos_next;
            MODE_GRAY: leds_next = pos_next ^ (pos_next >> 1);
            MODE_SCAN: leds_next = 5'd1 << pos_next[2:0];
            default:   leds_next = (5'd1 << pos_next[2:0]) - 5'd1;
        endcase
    end

    assign LEDS = leds_reg;
    assign MODE = mode_reg;

`ifdef LED_SEQ_STATUS_EN
    logic ledr_reg;
    logic ledg_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ledr_reg <= 1'b1;
            ledg_reg <= 1'b1;
        end else begin
            ledr_reg <= ~(|btn_stable);
            ledg_reg <= ~run_reg;
        end
    end

    assign LEDR_N = ledr_reg;
    assign LEDG_N = ledg_reg;
`else
    assign LEDR_N = 1'b1;
    assign LEDG_N = 1'b1;
`endif

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: vector table, directed corner sequences and random buttons against a cycle model.
module tb_led_mode_sequencer;

    localparam int LOG2DELAY     = 3;
    localparam int DEBOUNCE_BITS = 4;
    localparam int PDIV          = 1 << LOG2DELAY;
    localparam int DB_N          = 1 << DEBOUNCE_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       btn1 = 1'b0;
    logic       btn2 = 1'b0;
    logic       btn3 = 1'b0;
    logic [4:0] leds;
    logic [1:0] mode;
    logic       ledr_n;
    logic       ledg_n;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    led_mode_sequencer #(
        .LOG2DELAY    (LOG2DELAY),
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .BTN_N (btn_n),
        .BTN1  (btn1),
        .BTN2  (btn2),
        .BTN3  (btn3),
        .LEDS  (leds),
        .MODE  (mode),
        .LEDR_N(ledr_n),
        .LEDG_N(ledg_n)
    );

    always #5 clk = ~clk;

    // Reference model: mode/pos as integers, buttons indexed 0 restart, 1 next, 2 pause, 3 dir.
    int       m_mode, m_pos, m_presc;
    bit       m_run, m_dir;
    bit [4:0] m_leds;
    bit       m_ledr, m_ledg;
    bit       hist[4][3];
    bit       stab[4];
    int       runlen[4];
    bit       rose[4];
    bit       ev[4];

    function automatic int modulus(int md);
        if (md == 2) return 5;
        if (md == 3) return 6;
        return 32;
    endfunction

    function automatic int decode(int md, int p);
        case (md)
            0:       return p;
            1:       return p ^ (p / 2);
            2:       return 1 << p;
            default: return (1 << p) - 1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 1; m_pos = 0; m_presc = 0; m_run = 1'b1; m_dir = 1'b0;
        m_leds = '0; m_ledr = 1'b1; m_ledg = 1'b1;
        for (int b = 0; b < 4; b++) begin
            hist[b][0] = 1'b0; hist[b][1] = 1'b0; hist[b][2] = 1'b0;
            stab[b] = 1'b0; runlen[b] = 0; rose[b] = 1'b0; ev[b] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit raw[4];
        bit act[4];
        bit tick;
        int md;
        raw[0] = ~btn_n; raw[1] = btn1; raw[2] = btn2; raw[3] = btn3;
        if (rst) begin
            model_reset();
            return;
        end
        m_ledg = !m_run;
        m_ledr = !(stab[0] | stab[1] | stab[2] | stab[3]);
        act  = ev;
        tick = m_run && (m_presc == PDIV - 1);
        if (act[0]) begin
            m_mode = 1; m_run = 1'b1; m_dir = 1'b0; m_pos = 0; m_presc = 0;
        end else begin
            if (act[1]) begin
                m_mode = (m_mode + 1) % 4; m_pos = 0; m_presc = 0;
            end else begin
                if (m_run) m_presc = (m_presc + 1) % PDIV;
                if (tick) begin
                    md = modulus(m_mode);
                    m_pos = m_dir ? (m_pos + md - 1) % md : (m_pos + 1) % md;
                end
            end
            if (act[2]) m_run = !m_run;
            if (act[3]) m_dir = !m_dir;
        end
        m_leds = 5'(decode(m_mode, m_pos));
        // A press reaches the debouncer three edges late; stable flips on the DB_N-th differing edge in a row.
        for (int b = 0; b < 4; b++) begin
            bit seen;
            seen = hist[b][2];
            ev[b] = rose[b];
            rose[b] = 1'b0;
            hist[b][2] = hist[b][1]; hist[b][1] = hist[b][0]; hist[b][0] = raw[b];
            if (seen != stab[b]) begin
                runlen[b]++;
                if (runlen[b] == DB_N) begin
                    stab[b] = seen; runlen[b] = 0; rose[b] = seen;
                end
            end else begin
                runlen[b] = 0;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic step();
        logic [8:0] exp;
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
`ifdef LED_SEQ_STATUS_EN
        exp = {m_leds, 2'(m_mode), m_ledr, m_ledg};
`else
        exp = {m_leds, 2'(m_mode), 1'b1, 1'b1};
`endif
        check("model{leds,mode,ledr_n,ledg_n}", {23'd0, leds, mode, ledr_n, ledg_n}, {23'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       btn_n;
        logic       btn1;
        logic       btn2;
        logic       btn3;
        int         hold;
        logic [4:0] leds;
        logic [1:0] mode;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n;
        model_reset();

        // Reset, Gray count every 8 edges, short BTN1 glitch, long BTN1 hold into SCAN.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2,  5'd0,  2'd1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7,  5'd0,  2'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  5'd1,  2'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd3,  2'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd2,  2'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd6,  2'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd7,  2'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10, 5'd5,  2'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20, 5'd12, 2'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20, 5'd14, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1,  5'd1,  2'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9,  5'd2,  2'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd4,  2'd2};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd8,  2'd2};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd16, 2'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8,  5'd1,  2'd2};

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; btn_n = vecs[i].btn_n; btn1 = vecs[i].btn1;
            btn2 = vecs[i].btn2; btn3 = vecs[i].btn3;
            repeat (vecs[i].hold) step();
            check($sformatf("vec%0d.leds", i), {27'd0, leds}, {27'd0, vecs[i].leds});
            check($sformatf("vec%0d.mode", i), {30'd0, mode}, {30'd0, vecs[i].mode});
            $display("vec %0d: cycle=%0d leds=%b mode=%0d", i, cycle, leds, mode);
        end
        btn1 = 1'b0;

        // Pause in BIN at pos 5, then resume.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            btn1 = 1'b1; repeat (25) step();
            btn1 = 1'b0; repeat (25) step();
        end
        check("bin.mode", {30'd0, mode}, 32'd0);
        n = 0;
        while (leds === 5'd3 && n < 300) begin step(); n++; end
        while (leds !== 5'd3 && n < 300) begin step(); n++; end
        check("bin.at3", {27'd0, leds}, 32'd3);
        btn2 = 1'b1;
        repeat (21) step();
        check("pause.applied", {27'd0, leds}, 32'd5);
        repeat (4) step();
        btn2 = 1'b0;
        repeat (175) step();
        check("pause.frozen", {27'd0, leds}, 32'd5);
        check("pause.ledg_n", {31'd0, ledg_n}, 32'd1);
        $display("pause: cycle=%0d leds=%b ledg_n=%b", cycle, leds, ledg_n);
        btn2 = 1'b1;
        n = 0;
        while (leds === 5'd5 && n < 60) begin step(); n++; end
        check("resume.leds", {27'd0, leds}, 32'd6);
        btn2 = 1'b0;
        repeat (25) step();

        // Next and direction together into BAR, then step down from pos 0.
        do_reset();
        btn1 = 1'b1; repeat (25) step();
        btn1 = 1'b0; repeat (25) step();
        btn1 = 1'b1; btn3 = 1'b1;
        n = 0;
        while (mode !== 2'd3 && n < 40) begin step(); n++; end
        check("bar.entry_edges", n, 32'd21);
        check("bar.leds0", {27'd0, leds}, 32'd0);
        btn1 = 1'b0; btn3 = 1'b0;
        repeat (8) step();
        check("bar.down_wrap", {27'd0, leds}, 32'd31);
        repeat (8) step();
        check("bar.down4", {27'd0, leds}, 32'd15);
        $display("bar: cycle=%0d leds=%b", cycle, leds);

        // SCAN, paused, down via one combined press; then restart with next in the same cycle.
        do_reset();
        btn1 = 1'b1; btn2 = 1'b1; btn3 = 1'b1;
        n = 0;
        while (mode !== 2'd2 && n < 40) begin step(); n++; end
        check("scan.leds", {27'd0, leds}, 32'd1);
        btn1 = 1'b0; btn2 = 1'b0; btn3 = 1'b0;
        repeat (40) step();
        check("scan.paused", {27'd0, leds}, 32'd1);
        btn_n = 1'b0; btn1 = 1'b1;
        n = 0;
        while (mode === 2'd2 && n < 40) begin step(); n++; end
        check("restart.edges", n, 32'd21);
        check("restart.mode", {30'd0, mode}, 32'd1);
        check("restart.leds", {27'd0, leds}, 32'd0);
        btn_n = 1'b1; btn1 = 1'b0;
        repeat (8) step();
        check("restart.run_up", {27'd0, leds}, 32'd1);
        $display("restart: cycle=%0d leds=%b mode=%0d", cycle, leds, mode);

        // Reset during BTN1 debounce.
        btn1 = 1'b1;
        repeat (10) step();
        rst = 1'b1; btn1 = 1'b0;
        step();
        check("rst.outputs", {23'd0, leds, mode, ledr_n, ledg_n}, {23'd0, 5'd0, 2'd1, 1'b1, 1'b1});
        rst = 1'b0;
        repeat (40) step();
        check("rst.no_event", {30'd0, mode}, 32'd1);
        $display("rst: cycle=%0d leds=%b mode=%0d", cycle, leds, mode);

        // Random buttons and occasional resets against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(29) == 0) btn_n = ~btn_n;
            if ($urandom_range(29) == 0) btn1 = ~btn1;
            if ($urandom_range(29) == 0) btn2 = ~btn2;
            if ($urandom_range(29) == 0) btn3 = ~btn3;
            rst = ($urandom_range(1999) == 0);
            step();
            if (c % 1000 == 999)
                $display("random: cycle=%0d leds=%b mode=%0d errors=%0d", cycle, leds, mode, errors);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
